// File: rtl/mic_pkg.sv
// Shared definitions for the mic_delay_sum beamformer: FSM states, gain
// encoding and the configuration address map.
package mic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_SCALE = 3'd4,
        S_CLEAR = 3'd5
    } mic_state_e;

    localparam logic [7:0] GAIN_UNITY     = 8'h10;
    localparam int         GAIN_FRAC_BITS = 4;

    // The gain register sits directly after the per-channel delay registers.
    function automatic logic [4:0] cfg_gain_addr(input int nch);
        return nch[4:0];
    endfunction

endpackage

// File: rtl/mic_sample_ram.sv
// Single-port synchronous sample history RAM with a registered read port,
// shaped so it maps onto block RAM.
module mic_sample_ram #(
    parameter int WIDTH = 16,
    parameter int WORDS = 384,
    parameter int AW    = 9
) (
    input  logic             ck,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Write port and one-cycle registered read share the single address.
    always_ff @(posedge ck) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mic_delay_sum.sv
// Delay-and-sum beamformer: stores per-channel history, sums delayed taps,
// scales by a Q4.4 gain and saturates. Define MIC_DELAY_SUM_CLEAR_EN to zero the history RAM after reset.
module mic_delay_sum
    import mic_pkg::*;
#(
    parameter  int NCH   = 6,
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    localparam int DW    = $clog2(DEPTH)
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic [NCH*WIDTH-1:0] sample_in,
    input  logic                 cfg_we,
    input  logic [4:0]           cfg_addr,
    input  logic [7:0]           cfg_data,
    output logic [WIDTH-1:0]     out_sample,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW   = CHW + DW;
    localparam int ACCW = WIDTH + $clog2(NCH) + 1;
    localparam int PW   = ACCW + 9;

    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCH - 1);
    localparam logic [4:0]     NCH_ADDR  = 5'(NCH);
    localparam logic [4:0]     GAIN_ADDR = cfg_gain_addr(NCH);
    localparam logic [AW-1:0]  LAST_WORD = AW'(NCH * DEPTH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [ACCW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(ACCW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] scale_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> GAIN_FRAC_BITS;
        if (s > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return s[WIDTH-1:0];
        end
    endfunction

    mic_state_e                    state_q, state_d;
    logic [CHW-1:0]                ch_q, ch_d;
    logic [DW-1:0]                 wp_q, wp_d;
    logic signed [ACCW-1:0]        acc_q, acc_d;
    logic                          rd_pend_q, rd_pend_d;
    logic [NCH-1:0][WIDTH-1:0]     frame_q, frame_d;
    logic [NCH-1:0][DW-1:0]        dly_stg_q, dly_stg_d;
    logic [NCH-1:0][DW-1:0]        dly_q, dly_d;
    logic [7:0]                    gain_stg_q, gain_stg_d;
    logic [7:0]                    gain_q, gain_d;
    logic signed [PW-1:0]          prod_q, prod_d;
    logic                          prod_v_q, prod_v_d;
    logic [WIDTH-1:0]              out_sample_q, out_sample_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;
    logic [AW-1:0]                 clr_cnt_q, clr_cnt_d;

    logic                          ram_we_s;
    logic [AW-1:0]                 ram_addr_s;
    logic [WIDTH-1:0]              ram_wdata_s;
    logic [WIDTH-1:0]              ram_rdata_s;
    logic [DW-1:0]                 rd_ptr_s;

    mic_sample_ram #(
        .WIDTH (WIDTH),
        .WORDS (NCH * DEPTH),
        .AW    (AW)
    ) u_ram (
        .ck    (ck),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, datapath and RAM port control.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        wp_d         = wp_q;
        acc_d        = acc_q;
        rd_pend_d    = rd_pend_q;
        frame_d      = frame_q;
        dly_stg_d    = dly_stg_q;
        dly_d        = dly_q;
        gain_stg_d   = gain_stg_q;
        gain_d       = gain_q;
        prod_d       = prod_q;
        prod_v_d     = 1'b0;
        clr_cnt_d    = clr_cnt_q;
        rd_ptr_s     = wp_q - dly_q[ch_q];
        ram_we_s     = 1'b0;
        ram_addr_s   = {ch_q, wp_q};
        ram_wdata_s  = frame_q[ch_q];

        if (cfg_we && (cfg_addr < NCH_ADDR)) begin
            dly_stg_d[cfg_addr[CHW-1:0]] = cfg_data[DW-1:0];
        end else if (cfg_we && (cfg_addr == GAIN_ADDR)) begin
            gain_stg_d = cfg_data;
        end else begin
            gain_stg_d = gain_stg_q;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    frame_d = sample_in;
                    dly_d   = dly_stg_q;
                    gain_d  = gain_stg_q;
                    ch_d    = {CHW{1'b0}};
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                ram_we_s = 1'b1;
                if (ch_q == LAST_CH) begin
                    ch_d      = {CHW{1'b0}};
                    acc_d     = {ACCW{1'b0}};
                    rd_pend_d = 1'b0;
                    state_d   = S_READ;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
            end
            S_READ: begin
                // Each cycle issues channel ch and accumulates channel ch-1.
                ram_addr_s = {ch_q, rd_ptr_s};
                rd_pend_d  = 1'b1;
                if (rd_pend_q) begin
                    acc_d = acc_q + sext(ram_rdata_s);
                end else begin
                    acc_d = acc_q;
                end
                if (ch_q == LAST_CH) begin
                    state_d = S_FLUSH;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
            end
            S_FLUSH: begin
                acc_d     = acc_q + sext(ram_rdata_s);
                rd_pend_d = 1'b0;
                state_d   = S_SCALE;
            end
            S_SCALE: begin
                prod_d   = $signed(acc_q) * $signed({1'b0, gain_q});
                prod_v_d = 1'b1;
                wp_d     = wp_q + DW'(1);
                state_d  = S_IDLE;
            end
`ifdef MIC_DELAY_SUM_CLEAR_EN
            S_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_addr_s  = clr_cnt_q;
                ram_wdata_s = {WIDTH{1'b0}};
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturation runs one cycle after the multiply to keep the paths short.
        out_valid_d  = prod_v_q;
        if (prod_v_q) begin
            out_sample_d = scale_sat(prod_q);
        end else begin
            out_sample_d = out_sample_q;
        end

        busy_d    = (state_d != S_IDLE);
        overrun_d = overrun_q | (sample_valid & (state_q != S_IDLE));
    end

    // State and datapath registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
`ifdef MIC_DELAY_SUM_CLEAR_EN
            state_q <= S_CLEAR;
`else
            state_q <= S_IDLE;
`endif
            ch_q         <= {CHW{1'b0}};
            wp_q         <= {DW{1'b0}};
            acc_q        <= {ACCW{1'b0}};
            rd_pend_q    <= 1'b0;
            frame_q      <= {(NCH*WIDTH){1'b0}};
            dly_stg_q    <= {(NCH*DW){1'b0}};
            dly_q        <= {(NCH*DW){1'b0}};
            gain_stg_q   <= GAIN_UNITY;
            gain_q       <= GAIN_UNITY;
            prod_q       <= {PW{1'b0}};
            prod_v_q     <= 1'b0;
            out_sample_q <= {WIDTH{1'b0}};
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            clr_cnt_q    <= {AW{1'b0}};
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            wp_q         <= wp_d;
            acc_q        <= acc_d;
            rd_pend_q    <= rd_pend_d;
            frame_q      <= frame_d;
            dly_stg_q    <= dly_stg_d;
            dly_q        <= dly_d;
            gain_stg_q   <= gain_stg_d;
            gain_q       <= gain_d;
            prod_q       <= prod_d;
            prod_v_q     <= prod_v_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
